// File: rtl/bp_me_addr_router.sv
// bp_me_addr_router
// Routes one command stream to num_dev_p local devices or the memory port,
// and returns the responses strictly in command order.
//
// Decode of cmd_addr_i:
//   non-local address (upper bits nonzero) -> memory port (index num_dev_p)
//   local, device ID <  num_dev_p          -> port ID
//   local, device ID >= num_dev_p          -> internal error target
// The error target always accepts, and answers with all-ones data and
// resp_err_o set.
//
// An order FIFO of outstanding_p entries records {err, port} for each
// accepted command. Its head selects the single port whose response may be
// returned next. Responses from other ports wait, and get no yumi, until
// their entry reaches the head.
//
// Ports:
//   clk_i, reset_n_i                       clock, async active-low reset
//   cmd_v_i / cmd_ready_o                  request handshake
//   cmd_addr_i, cmd_data_i, cmd_we_i       request fields
//   dev_cmd_v_o[num_dev_p:0]               one-hot forward valid
//   dev_cmd_addr_o/data_o/we_o             shared pass-through of cmd fields
//   dev_cmd_ready_i[num_dev_p:0]           per-port ready
//   dev_resp_v_i, dev_resp_data_i          per-port responses
//   dev_resp_yumi_o                        per-port response consume
//   resp_v_o, resp_data_o, resp_err_o      ordered response to requester
//   resp_yumi_i                            requester consumes response
module bp_me_addr_router #(
  parameter int num_dev_p            = 6,
  parameter int paddr_width_p        = 56,
  parameter int data_width_p         = 64,
  parameter int local_region_width_p = 24,
  parameter int dev_id_lsb_p         = 20,
  parameter int outstanding_p        = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,

  input  logic                                  cmd_v_i,
  output logic                                  cmd_ready_o,
  input  logic [paddr_width_p-1:0]              cmd_addr_i,
  input  logic [data_width_p-1:0]               cmd_data_i,
  input  logic                                  cmd_we_i,

  output logic [num_dev_p:0]                    dev_cmd_v_o,
  output logic [paddr_width_p-1:0]              dev_cmd_addr_o,
  output logic [data_width_p-1:0]               dev_cmd_data_o,
  output logic                                  dev_cmd_we_o,
  input  logic [num_dev_p:0]                    dev_cmd_ready_i,

  input  logic [num_dev_p:0]                    dev_resp_v_i,
  input  logic [(num_dev_p+1)*data_width_p-1:0] dev_resp_data_i,
  output logic [num_dev_p:0]                    dev_resp_yumi_o,

  output logic                                  resp_v_o,
  output logic [data_width_p-1:0]               resp_data_o,
  output logic                                  resp_err_o,
  input  logic                                  resp_yumi_i
);

  localparam int port_w = $clog2(num_dev_p + 1);
  localparam int ptr_w  = $clog2(outstanding_p);
  localparam int cnt_w  = $clog2(outstanding_p + 1);
  localparam int id_w   = local_region_width_p - dev_id_lsb_p;

  typedef struct packed {
    logic              err;
    logic [port_w-1:0] port;
  } entry_t;

  // Order FIFO state
  entry_t             mem_q [outstanding_p];
  logic [ptr_w-1:0]   wptr_q, rptr_q;
  logic [cnt_w-1:0]   count_q, count_d;

  // Decode
  logic [id_w-1:0]    dev_id;
  entry_t             dec;
  logic               tgt_ready;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  entry_t             head;

  assign dev_id = cmd_addr_i[local_region_width_p-1:dev_id_lsb_p];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    dec.err  = 1'b0;
    dec.port = port_w'(num_dev_p);
    if (~|cmd_addr_i[paddr_width_p-1:local_region_width_p]) begin
      if (32'(dev_id) < 32'(num_dev_p)) begin
        dec.port = port_w'(dev_id);
      end else begin
        dec.err  = 1'b1;
        dec.port = '0;
      end
    end
  end

  assign fifo_full  = (count_q == cnt_w'(outstanding_p));
  assign fifo_empty = (count_q == '0);
  assign tgt_ready  = dec.err | dev_cmd_ready_i[dec.port];

  // reset_n_i gates the outputs directly so they are quiet during reset
  // regardless of what the inputs are doing.
  assign cmd_ready_o = reset_n_i & tgt_ready & ~fifo_full;
  assign push        = cmd_v_i & cmd_ready_o;

  always_comb begin
    dev_cmd_v_o = '0;
    if (reset_n_i && cmd_v_i && !fifo_full && !dec.err) begin
      dev_cmd_v_o[dec.port] = 1'b1;
    end
  end

  assign dev_cmd_addr_o = cmd_addr_i;
  assign dev_cmd_data_o = cmd_data_i;
  assign dev_cmd_we_o   = cmd_we_i;

  // Response path: head of the order FIFO picks the source.
  assign head = mem_q[rptr_q];

  always_comb begin
    resp_v_o    = 1'b0;
    resp_err_o  = 1'b0;
    resp_data_o = dev_resp_data_i[head.port*data_width_p +: data_width_p];
    if (head.err) begin
      resp_data_o = '1;
    end
    // count_q is cleared asynchronously, so an empty FIFO also covers reset.
    if (!fifo_empty) begin
      resp_err_o = head.err;
      resp_v_o   = head.err | dev_resp_v_i[head.port];
    end
  end

  assign pop = resp_yumi_i & resp_v_o;

  always_comb begin
    dev_resp_yumi_o = '0;
    if (pop && !head.err) begin
      dev_resp_yumi_o[head.port] = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // Pointers are log2(depth) wide, so they wrap modulo the depth.
      if (push) wptr_q <= wptr_q + ptr_w'(1);
      if (pop)  rptr_q <= rptr_q + ptr_w'(1);
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage has no reset; count_q alone defines which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= dec;
    end
  end

endmodule

// File: tb/tb_bp_me_addr_router.sv
module tb_bp_me_addr_router;

  localparam int ND = 6;
  localparam int AW = 56;
  localparam int DW = 64;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 cmd_v, cmd_ready, cmd_we;
  logic [AW-1:0]        cmd_addr;
  logic [DW-1:0]        cmd_data;
  logic [ND:0]          dev_cmd_v, dev_cmd_ready;
  logic [AW-1:0]        dev_cmd_addr;
  logic [DW-1:0]        dev_cmd_data;
  logic                 dev_cmd_we;
  logic [ND:0]          dev_resp_v, dev_resp_yumi;
  logic [(ND+1)*DW-1:0] dev_resp_data;
  logic                 resp_v, resp_err, resp_yumi;
  logic [DW-1:0]        resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_me_addr_router dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .cmd_v_i         (cmd_v),
    .cmd_ready_o     (cmd_ready),
    .cmd_addr_i      (cmd_addr),
    .cmd_data_i      (cmd_data),
    .cmd_we_i        (cmd_we),
    .dev_cmd_v_o     (dev_cmd_v),
    .dev_cmd_addr_o  (dev_cmd_addr),
    .dev_cmd_data_o  (dev_cmd_data),
    .dev_cmd_we_o    (dev_cmd_we),
    .dev_cmd_ready_i (dev_cmd_ready),
    .dev_resp_v_i    (dev_resp_v),
    .dev_resp_data_i (dev_resp_data),
    .dev_resp_yumi_o (dev_resp_yumi),
    .resp_v_o        (resp_v),
    .resp_data_o     (resp_data),
    .resp_err_o      (resp_err),
    .resp_yumi_i     (resp_yumi)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic [63:0] pdata(input int p);
    return 64'h1111_1111_1111_1111 * 64'(p + 1);
  endfunction

  function automatic logic [AW-1:0] paddr(input int p);
    return AW'(p) << 20;
  endfunction

  task automatic idle;
    cmd_v         = 1'b0;
    dev_resp_v    = '0;
    resp_yumi     = 1'b0;
    dev_cmd_ready = '1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p <= ND; p++) dev_resp_data[p*DW +: DW] = pdata(p);

    // Reset with every input pushing for activity
    reset_n       = 1'b0;
    cmd_v         = 1'b1;
    cmd_addr      = '0;
    cmd_data      = 64'hDEAD_BEEF_0000_0001;
    cmd_we        = 1'b1;
    dev_cmd_ready = '1;
    dev_resp_v    = '1;
    resp_yumi     = 1'b1;
    #2;
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    check("rst_dev_cmd_v", 64'(dev_cmd_v), 0);
    check("rst_resp_v", 64'(resp_v), 0);
    check("rst_dev_yumi", 64'(dev_resp_yumi), 0);
    check("rst_count", 64'(dut.count_q), 0);
    tick; tick;
    idle;
    reset_n = 1'b1;

    // T1: local ID 3
    tick;
    cmd_v         = 1'b1;
    cmd_addr      = 56'h30_4000;
    cmd_data      = 64'hA5A5_5A5A_0123_4567;
    dev_cmd_ready = 7'b0001000;
    settle;
    check("t1_dev_cmd_v", 64'(dev_cmd_v), 64'b0001000);
    check("t1_cmd_ready", 64'(cmd_ready), 1);
    check("t1_data_pass", dev_cmd_data, 64'hA5A5_5A5A_0123_4567);
    tick;
    cmd_v = 1'b0;
    settle;
    check("t1_count", 64'(dut.count_q), 1);
    check("t1_resp_v_idle", 64'(resp_v), 0);
    dev_resp_v = 7'b0001000;
    settle;
    check("t1_resp_v", 64'(resp_v), 1);
    check("t1_resp_data", resp_data, pdata(3));
    check("t1_resp_err", 64'(resp_err), 0);
    check("t1_yumi_hold", 64'(dev_resp_yumi), 0);
    resp_yumi = 1'b1;
    settle;
    check("t1_yumi", 64'(dev_resp_yumi), 64'b0001000);
    tick;
    idle;
    settle;
    check("t1_count_after", 64'(dut.count_q), 0);
    check("t1_resp_v_after", 64'(resp_v), 0);

    // T2: error target (ID 7) then memory port
    dev_cmd_ready = '0;
    cmd_v         = 1'b1;
    cmd_addr      = 56'h70_0000;
    settle;
    check("t2_err_dev_cmd_v", 64'(dev_cmd_v), 0);
    check("t2_err_ready", 64'(cmd_ready), 1);
    tick;
    cmd_v = 1'b0;
    settle;
    check("t2_err_resp_v", 64'(resp_v), 1);
    check("t2_err_resp_err", 64'(resp_err), 1);
    check("t2_err_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    cmd_v    = 1'b1;
    cmd_addr = 56'h80_0000_0000;
    settle;
    check("t2_p6_dev_cmd_v", 64'(dev_cmd_v), 64'b1000000);
    check("t2_p6_blocked", 64'(cmd_ready), 0);
    dev_cmd_ready = 7'b1000000;
    settle;
    check("t2_p6_ready", 64'(cmd_ready), 1);
    tick;
    cmd_v = 1'b0;
    settle;
    check("t2_count", 64'(dut.count_q), 2);
    resp_yumi = 1'b1;
    settle;
    check("t2_err_no_dev_yumi", 64'(dev_resp_yumi), 0);
    tick;
    resp_yumi = 1'b0;
    settle;
    check("t2_p6_wait_v", 64'(resp_v), 0);
    check("t2_p6_wait_err", 64'(resp_err), 0);
    dev_resp_v = 7'b1000000;
    resp_yumi  = 1'b1;
    settle;
    check("t2_p6_data", resp_data, pdata(6));
    check("t2_p6_yumi", 64'(dev_resp_yumi), 64'b1000000);
    tick;
    idle;
    settle;
    check("t2_count_after", 64'(dut.count_q), 0);

    // T3: ports 2 then 5, port 5 answers first
    cmd_v    = 1'b1;
    cmd_addr = paddr(2);
    tick;
    cmd_addr = paddr(5);
    tick;
    cmd_v      = 1'b0;
    dev_resp_v = 7'b0100000;
    resp_yumi  = 1'b1;
    settle;
    check("t3_held_resp_v", 64'(resp_v), 0);
    check("t3_held_yumi", 64'(dev_resp_yumi), 0);
    tick;
    check("t3_held_count", 64'(dut.count_q), 2);
    dev_resp_v = 7'b0100100;
    settle;
    check("t3_p2_data", resp_data, pdata(2));
    check("t3_p2_yumi", 64'(dev_resp_yumi), 64'b0000100);
    tick;
    dev_resp_v = 7'b0100000;
    settle;
    check("t3_p5_data", resp_data, pdata(5));
    check("t3_p5_yumi", 64'(dev_resp_yumi), 64'b0100000);
    tick;
    idle;
    settle;
    check("t3_count_after", 64'(dut.count_q), 0);

    // T4: fill to full, pop frees one slot, then pointer wrap
    cmd_v    = 1'b1;
    cmd_addr = paddr(0);
    repeat (4) tick;
    check("t4_full_ready", 64'(cmd_ready), 0);
    check("t4_full_dev_v", 64'(dev_cmd_v), 0);
    check("t4_full_count", 64'(dut.count_q), 4);
    dev_resp_v = 7'b0000001;
    resp_yumi  = 1'b1;
    settle;
    check("t4_pop_full_ready", 64'(cmd_ready), 0);
    check("t4_pop_full_data", resp_data, pdata(0));
    tick;
    dev_resp_v = '0;
    resp_yumi  = 1'b0;
    settle;
    check("t4_after_pop_count", 64'(dut.count_q), 3);
    check("t4_after_pop_ready", 64'(cmd_ready), 1);
    tick;
    cmd_v = 1'b0;
    check("t4_refill_count", 64'(dut.count_q), 4);
    dev_resp_v = 7'b0000001;
    resp_yumi  = 1'b1;
    repeat (4) begin
      settle;
      check("t4_drain_v", 64'(resp_v), 1);
      tick;
    end
    idle;
    settle;
    check("t4_drain_count", 64'(dut.count_q), 0);
    for (int i = 0; i < 10; i++) begin
      cmd_v    = 1'b1;
      cmd_addr = paddr(i % 6);
      if (i > 0) begin
        dev_resp_v = 7'b1 << ((i - 1) % 6);
        resp_yumi  = 1'b1;
        settle;
        check("t4_wrap_data", resp_data, pdata((i - 1) % 6));
        check("t4_wrap_yumi", 64'(dev_resp_yumi), 64'(7'b1 << ((i - 1) % 6)));
      end
      tick;
      check("t4_wrap_count", 64'(dut.count_q), 1);
    end
    cmd_v      = 1'b0;
    dev_resp_v = 7'b0001000;
    resp_yumi  = 1'b1;
    settle;
    check("t4_wrap_last_data", resp_data, pdata(3));
    tick;
    idle;
    settle;
    check("t4_wrap_end_count", 64'(dut.count_q), 0);

    // T5: reset with three outstanding
    cmd_v    = 1'b1;
    cmd_addr = paddr(1);
    tick;
    cmd_addr = paddr(2);
    tick;
    cmd_addr = paddr(4);
    tick;
    cmd_v      = 1'b0;
    dev_resp_v = 7'b0000010;
    settle;
    check("t5_pre_count", 64'(dut.count_q), 3);
    check("t5_pre_resp_v", 64'(resp_v), 1);
    reset_n = 1'b0;
    settle;
    check("t5_rst_resp_v", 64'(resp_v), 0);
    check("t5_rst_count", 64'(dut.count_q), 0);
    tick;
    reset_n    = 1'b1;
    dev_resp_v = '1;
    resp_yumi  = 1'b1;
    repeat (2) begin
      settle;
      check("t5_post_resp_v", 64'(resp_v), 0);
      check("t5_post_yumi", 64'(dev_resp_yumi), 0);
      tick;
    end
    idle;

    // T6: head valid, requester stalls
    cmd_v    = 1'b1;
    cmd_addr = paddr(1);
    tick;
    cmd_v      = 1'b0;
    dev_resp_v = 7'b0000010;
    resp_yumi  = 1'b0;
    repeat (3) begin
      settle;
      check("t6_stall_v", 64'(resp_v), 1);
      check("t6_stall_data", resp_data, pdata(1));
      check("t6_stall_yumi", 64'(dev_resp_yumi), 0);
      tick;
    end
    resp_yumi = 1'b1;
    tick;
    idle;
    settle;
    check("t6_count_after", 64'(dut.count_q), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_me_addr_router.md
BP_ME_ADDR_ROUTER -- requirements
Module: bp_me_addr_router

Interface
REQ-001 The block SHALL have parameter num_dev_p, default 6, giving the number of local devices; local IDs are 0..num_dev_p-1, and the memory port index is num_dev_p.
REQ-002 The block SHALL have parameter paddr_width_p, default 56, giving the physical address width.
REQ-003 The block SHALL have parameter data_width_p, default 64, giving the command and response data width.
REQ-004 The block SHALL have parameter local_region_width_p, default 24; an address is local when all bits above local_region_width_p-1 are zero.
REQ-005 The block SHALL have parameter dev_id_lsb_p, default 20; the device ID is addr[local_region_width_p-1:dev_id_lsb_p].
REQ-006 The block SHALL have parameter outstanding_p, default 4, giving the order-tracking FIFO depth (a power of 2, at least 2).
REQ-007 clk_i  in  1  clock; all logic is on the rising edge.
REQ-008 reset_n_i  in  1  asynchronous reset, active-low.
REQ-009 cmd_v_i / cmd_ready_o  in / out  1 / 1  request valid-ready handshake.
REQ-010 cmd_addr_i, cmd_data_i, cmd_we_i  in  paddr_width_p, data_width_p, 1  request address, write data, write enable.
REQ-011 dev_cmd_v_o  out  num_dev_p+1  one-hot forward valid; dev_cmd_addr_o, dev_cmd_data_o, dev_cmd_we_o  out  (shared) pass-through of the cmd fields.
REQ-012 dev_cmd_ready_i  in  num_dev_p+1  per-port ready.
REQ-013 dev_resp_v_i  in  num_dev_p+1; dev_resp_data_i  in  (num_dev_p+1)*data_width_p; dev_resp_yumi_o  out  num_dev_p+1.
REQ-014 resp_v_o  out  1; resp_data_o  out  data_width_p; resp_err_o  out  1; resp_yumi_i  in  1.

Function
REQ-015 The decode SHALL work as follows: non-local -> port num_dev_p; local with ID < num_dev_p -> port ID; local with ID >= num_dev_p -> internal error target.
REQ-016 The target ready SHALL be dev_cmd_ready_i[port] for a real port and constant 1 for the error target.
REQ-017 cmd_ready_o SHALL equal target ready AND NOT fifo_full, and SHALL be a combinational function of cmd_addr_i, dev_cmd_ready_i and the FIFO count only.
REQ-018 dev_cmd_v_o[port] SHALL equal cmd_v_i AND NOT fifo_full, and all other bits SHALL be 0; an error target SHALL drive no dev_cmd_v_o bit.
REQ-019 On handshake (cmd_v_i & cmd_ready_o), {port, err} SHALL be pushed into the order FIFO in the same edge.
REQ-020 The FIFO head SHALL select the response source: for a real port, resp_v_o = dev_resp_v_i[head], resp_data_o = that port's slice, and resp_err_o = 0.
REQ-021 For an error head, resp_v_o SHALL be 1, resp_data_o SHALL be all ones, and resp_err_o SHALL be 1.
REQ-022 dev_resp_yumi_o[head] SHALL equal resp_yumi_i & resp_v_o (real port only), all other bits SHALL be 0, and the FIFO SHALL pop on resp_yumi_i & resp_v_o.
REQ-023 Responses from non-head ports SHALL be held (no yumi) until that port reaches the head; responses SHALL be returned strictly in command order.
REQ-024 When the FIFO is empty, resp_v_o and all dev_resp_yumi_o bits SHALL be 0.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged; a pop while full SHALL NOT enable a push in the same cycle (cmd_ready_o = 0 when full).
REQ-026 Read and write pointers SHALL wrap modulo outstanding_p, and the count SHALL range 0..outstanding_p.
REQ-027 Command path latency SHALL be 0 cycles (combinational forward); response path latency SHALL be 0 cycles from dev_resp_v_i at the head.
REQ-028 An error response SHALL be available the cycle after its command is accepted, provided it is at the head.
REQ-029 resp_yumi_i asserted while resp_v_o = 0 SHALL be ignored.

Reset
REQ-030 While reset_n_i = 0, the FIFO pointers and count SHALL be 0 immediately (asynchronous).
REQ-031 While reset_n_i = 0, cmd_ready_o, resp_v_o, dev_cmd_v_o and dev_resp_yumi_o SHALL be 0, irrespective of the inputs.
REQ-032 Reset asserted mid-operation SHALL discard all outstanding entries, with no response issued for them.
REQ-033 After reset_n_i rises, the first command SHALL be accepted no earlier than the next rising edge.

Verification
REQ-034 The bench SHALL cover: addr 0x0030_4000 with dev_cmd_ready_i[3] = 1 -> dev_cmd_v_o = 0000_1000b, handshake, FIFO count 1.
REQ-035 The bench SHALL cover: addr 0x80_0000_0000 -> port 6 selected; addr 0x0070_0000 (ID 7) -> no dev_cmd_v_o, cmd_ready_o = 1, next response resp_err_o = 1 with data 0xFFFF_FFFF_FFFF_FFFF.
REQ-036 The bench SHALL cover: commands to ports 2 then 5, with port 5 responding first -> port 5 held (yumi 0) until port 2's response is consumed, then delivered.
REQ-037 The bench SHALL cover: four accepted commands with no responses -> cmd_ready_o = 0 on the 5th; one pop -> the next command is accepted the following cycle, and the pointers wrap correctly over 10 transactions.
REQ-038 The bench SHALL cover: reset_n_i pulsed low with 3 outstanding -> immediately resp_v_o = 0 and count 0, and later device responses are never forwarded.
REQ-039 The bench SHALL cover: resp_yumi_i held at 0 with the head valid -> resp_v_o and resp_data_o stable, and no dev_resp_yumi_o asserted.
